alu_seq: RTL and testbench

//   Parametrised multi-cycle ALU for the CPU datapath. Successor to the 8-bit combinational ALU.

---
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Shifts run one bit per cycle.
// Build option ALU_MUL_EN: OP 111 becomes a W-cycle shift-add multiply; otherwise it passes A through.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [2:0]   OP,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         Zero,
  output logic         Sign,
  output logic         Carry
);

  localparam int SHW = $clog2(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_RSH = 3'b001;
  localparam logic [2:0] OP_LSH = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           carry_q, carry_d;
  logic           zero_q, sign_q;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;

  logic [W:0]     sum, diff;
  logic [SHW-1:0] shamt;
  logic [W:0]     accept_shift, exec_shift;

  // Returns {bit shifted out, shifted value}; zero fill in both directions.
  function automatic logic [W:0] shift_one(input logic [W-1:0] v, input logic left);
    shift_one = left ? {v[W-1], v[W-2:0], 1'b0} : {v[0], 1'b0, v[W-1:1]};
  endfunction

  assign sum          = {1'b0, A} + {1'b0, B};
  assign diff         = {1'b0, A} - {1'b0, B};
  assign shamt        = B[SHW-1:0];
  assign accept_shift = shift_one(A, OP == OP_LSH);
  assign exec_shift   = shift_one(out_q, op_q == OP_LSH);

`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_sum;

  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef ALU_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = OP;
          state_d = ST_DONE;
          case (OP)
            OP_ADD: begin out_d = sum[W-1:0];  carry_d = sum[W];  end
            OP_SUB: begin out_d = diff[W-1:0]; carry_d = diff[W]; end
            OP_XOR: begin out_d = A ^ B; carry_d = 1'b0; end
            OP_AND: begin out_d = A & B; carry_d = 1'b0; end
            OP_OR:  begin out_d = A | B; carry_d = 1'b0; end
            OP_RSH, OP_LSH: begin
              if (shamt == '0) begin
                out_d   = A;
                carry_d = 1'b0;
              end else begin
                // First bit moves on the accept edge, so a count of n finishes n edges in.
                out_d   = accept_shift[W-1:0];
                carry_d = accept_shift[W];
                cnt_d   = shamt - CNT_ONE;
                if (shamt != CNT_ONE) state_d = ST_EXEC;
              end
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
              prod_d   = B[0] ? {{W{1'b0}}, A} : '0;
              mcand_d  = {{(W-1){1'b0}}, A, 1'b0};
              mplier_d = {1'b0, B[W-1:1]};
              cnt_d    = SHW'(W - 1);
              state_d  = ST_EXEC;
`else
              out_d   = A;
              carry_d = 1'b0;
`endif
            end
          endcase
        end
      end

      ST_EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          prod_d   = prod_sum;
          mcand_d  = {mcand_q[2*W-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[W-1:1]};
          if (cnt_q == CNT_ONE) begin
            out_d   = prod_sum[W-1:0];
            carry_d = |prod_sum[2*W-1:W];
          end
        end else begin
          out_d   = exec_shift[W-1:0];
          carry_d = exec_shift[W];
        end
`else
        out_d   = exec_shift[W-1:0];
        carry_d = exec_shift[W];
`endif
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      // Flags are registered so they read 0 out of reset even though out is 0.
      zero_q  <= ~|out_d;
      sign_q  <= out_d[W-1];
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
`endif

  assign in_ready  = (state_q == ST_IDLE) && !Reset;
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign Zero      = zero_q;
  assign Sign      = sign_q;
  assign Carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at W=8: vector table plus hold, and reset-abort sequences.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_RSH = 3'b001;
  localparam logic [2:0] OP_LSH = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_zero;
    logic       exp_sign;
    logic       exp_carry;
    int         exp_lat;
  } vec_t;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OP;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       Zero;
  logic       Sign;
  logic       Carry;

  int total = 0;
  int bad   = 0;

  vec_t vecs[16];

  alu_seq #(.W(8)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .Zero      (Zero),
    .Sign      (Sign),
    .Carry     (Carry)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op, measures edges from accept to out_valid, checks result, then retires it.
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    @(negedge CLK);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    A = v.a; B = v.b; OP = v.op; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_in_ready_busy"}, in_ready, 0);
      @(negedge CLK);
      lat++;
    end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_out"},     out,   v.exp_out);
    check({tag, "_zero"},    Zero,  v.exp_zero);
    check({tag, "_sign"},    Sign,  v.exp_sign);
    check({tag, "_carry"},   Carry, v.exp_carry);
    check({tag, "_in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_out_hold"},   out, v.exp_out);
  endtask

  initial begin
    int idle_valid;
    vec_t v;

    vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1};
    vecs[1]  = '{OP_RSH, 8'h81, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 3};
    vecs[2]  = '{OP_LSH, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{OP_LSH, 8'h05, 8'h08, 8'h05, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{OP_RSH, 8'hC0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 7};
    vecs[5]  = '{OP_XOR, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{OP_OR,  8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1, 1};
    vecs[9]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[10] = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1};
    vecs[11] = '{OP_LSH, 8'h01, 8'h07, 8'h80, 1'b0, 1'b1, 1'b0, 7};
    vecs[12] = '{OP_RSH, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1};
    vecs[13] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1};
`ifdef ALU_MUL_EN
    vecs[14] = '{OP_MUL, 8'h0C, 8'h0D, 8'h9C, 1'b0, 1'b1, 1'b0, 8};
    vecs[15] = '{OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 8};
`else
    vecs[14] = '{OP_MUL, 8'h0C, 8'h0D, 8'h0C, 1'b0, 1'b0, 1'b0, 1};
    vecs[15] = '{OP_MUL, 8'h90, 8'h10, 8'h90, 1'b0, 1'b1, 1'b0, 1};
`endif

    Reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    A = 8'h12; B = 8'h34; OP = OP_ADD;

    // Reset state, with in_valid held high to show nothing is accepted.
    repeat (2) @(negedge CLK);
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out",       out,       0);
    check("rst_zero",      Zero,      0);
    check("rst_sign",      Sign,      0);
    check("rst_carry",     Carry,     0);
    in_valid = 1'b0;
    Reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("v%0d", i), vecs[i]);
    end

    // Result held under back-pressure; new operands ignored meanwhile.
    @(negedge CLK);
    A = 8'h03; B = 8'h05; OP = OP_SUB; in_valid = 1'b1;
    @(negedge CLK);
    A = 8'h11; B = 8'h22; OP = OP_ADD;
    for (int k = 0; k < 4; k++) begin
      check("hold_valid",    out_valid, 1);
      check("hold_out",      out,       8'hFE);
      check("hold_sign",     Sign,      1);
      check("hold_carry",    Carry,     1);
      check("hold_in_ready", in_ready,  0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready,  1);
    check("hold_release_out",   out,       8'hFE);

    // Reset in the middle of a 7-cycle shift aborts it.
    @(negedge CLK);
    A = 8'hFF; B = 8'h07; OP = OP_RSH; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    check("abort_busy", in_ready, 0);
    repeat (2) @(negedge CLK);
    check("abort_busy_out", out, 8'h1F);
    #2 Reset = 1'b1;
    #1;
    check("abort_out",       out,       0);
    check("abort_zero",      Zero,      0);
    check("abort_sign",      Sign,      0);
    check("abort_carry",     Carry,     0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready",  in_ready,  0);
    @(negedge CLK);
    Reset = 1'b0;
    idle_valid = 0;
    repeat (10) begin
      @(negedge CLK);
      if (out_valid) idle_valid++;
    end
    check("abort_no_result", idle_valid, 0);

    v = '{OP_XOR, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    run_op("post_abort_xor", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
